// File: rtl/ulpi_link.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_link
//  Purpose  : ULPI link-layer stage between the PHY pins and a UTMI-style byte
//             interface. Handles bus turnaround, RX data / RX CMD decode,
//             TX CMD + packet transmit with STP, and PHY register writes.
//             Runs entirely in the 60 MHz ULPI clock domain.
//  Options  : ULPI_REG_READ_EN adds PHY register reads
//             (reg_re / reg_rdata / reg_rvalid).
//  Ports    : clk_i/rst_i         clock, synchronous active-high reset
//             ulpi_*              PHY side (data in/out/oe, dir, nxt, stp)
//             tx_*                packet source (first byte is the PID)
//             rx_*, linestate     receive side and line state
//             reg_*               PHY register access
//  Revision : 1.0  initial release
// ============================================================================
module ulpi_link #(
    parameter int TXCMD_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic [1:0] linestate,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       reg_we,
    output logic       reg_done,
`ifdef ULPI_REG_READ_EN
    input  logic       reg_re,
    output logic [7:0] reg_rdata,
    output logic       reg_rvalid,
`endif
    output logic       reg_busy
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        TX_CMD      = 4'd1,
        TX_DATA     = 4'd2,
        TX_STP      = 4'd3,
        REG_CMD     = 4'd4,
        REG_DATA    = 4'd5,
        REG_STP     = 4'd6
`ifdef ULPI_REG_READ_EN
        ,
        REG_RD_CMD  = 4'd7,
        REG_RD_TA   = 4'd8,
        REG_RD_DATA = 4'd9,
        REG_RD_WAIT = 4'd10
`endif
    } state_t;

    state_t      r_state, w_next;
    logic        r_dir_q;
    logic [7:0]  r_cmd;
    logic [15:0] r_to_cnt;
    logic        r_reg_busy;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_active, r_rx_error;
    logic [1:0]  r_linestate;

    logic        w_bus_free, w_is_cmd, w_timeout;
    logic [7:0]  w_data_o;
    logic        w_stp, w_tx_ready, w_tx_abort, w_reg_done;
    logic        w_start_tx, w_start_reg, w_start_rd, w_rd_capture;
    state_t      w_restart;

`ifdef ULPI_REG_READ_EN
    logic        r_reg_rd;      // pending access is a read
    logic [7:0]  r_reg_rdata;
    logic        r_reg_rvalid;
    assign w_restart = r_reg_rd ? REG_RD_CMD : REG_CMD;
    assign w_is_cmd  = (r_state == TX_CMD) || (r_state == REG_CMD) || (r_state == REG_RD_CMD);
`else
    assign w_restart = REG_CMD;
    assign w_is_cmd  = (r_state == TX_CMD) || (r_state == REG_CMD);
`endif

    // Link may drive only when DIR has been low for this and the previous cycle.
    assign w_bus_free = !ulpi_dir_i && !r_dir_q;

    assign w_timeout = (TXCMD_TIMEOUT != 0) && w_is_cmd && !ulpi_nxt_i &&
                       (r_to_cnt == 16'(TXCMD_TIMEOUT - 1));

    always_comb begin
        w_next       = r_state;
        w_data_o     = 8'h00;
        w_stp        = 1'b0;
        w_tx_ready   = 1'b0;
        w_tx_abort   = 1'b0;
        w_reg_done   = 1'b0;
        w_start_tx   = 1'b0;
        w_start_reg  = 1'b0;
        w_start_rd   = 1'b0;
        w_rd_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bus_free) begin
                    // A register access interrupted by the PHY resumes first.
                    if (r_reg_busy) begin
                        w_next = w_restart;
                    end else if (tx_valid) begin
                        w_next     = TX_CMD;
                        w_start_tx = 1'b1;
                    end else if (reg_we) begin
                        w_next      = REG_CMD;
                        w_start_reg = 1'b1;
                    end
`ifdef ULPI_REG_READ_EN
                    else if (reg_re) begin
                        w_next     = REG_RD_CMD;
                        w_start_rd = 1'b1;
                    end
`endif
                end
            end
            TX_CMD: begin
                w_data_o = r_cmd;
                if (ulpi_dir_i) begin
                    w_tx_abort = 1'b1;
                    w_next     = IDLE;
                end else if (ulpi_nxt_i) begin
                    w_tx_ready = 1'b1;          // PID consumed into the TX CMD
                    w_next     = tx_last ? TX_STP : TX_DATA;
                end else if (w_timeout) begin
                    w_tx_abort = 1'b1;
                    w_next     = IDLE;
                end
            end
            TX_DATA: begin
                w_data_o = tx_data;
                if (ulpi_dir_i) begin
                    w_tx_abort = 1'b1;
                    w_next     = IDLE;
                end else begin
                    w_tx_ready = ulpi_nxt_i;
                    if (ulpi_nxt_i && tx_last) w_next = TX_STP;
                end
            end
            TX_STP: begin
                w_stp  = 1'b1;
                w_next = IDLE;
            end
            REG_CMD: begin
                w_data_o = r_cmd;
                if (ulpi_dir_i) begin
                    w_next = IDLE;
                end else if (ulpi_nxt_i) begin
                    w_next = REG_DATA;
                end else if (w_timeout) begin
                    w_reg_done = 1'b1;          // give up without writing
                    w_next     = IDLE;
                end
            end
            REG_DATA: begin
                w_data_o = reg_wdata;
                if (ulpi_dir_i)      w_next = IDLE;
                else if (ulpi_nxt_i) w_next = REG_STP;
            end
            REG_STP: begin
                w_stp      = 1'b1;
                w_reg_done = 1'b1;
                w_next     = IDLE;
            end
`ifdef ULPI_REG_READ_EN
            REG_RD_CMD: begin
                w_data_o = r_cmd;
                if (ulpi_dir_i) begin
                    w_next = IDLE;
                end else if (ulpi_nxt_i) begin
                    w_next = REG_RD_TA;
                end else if (w_timeout) begin
                    w_reg_done = 1'b1;
                    w_next     = IDLE;
                end
            end
            REG_RD_TA: begin
                if (ulpi_dir_i) w_next = REG_RD_DATA;
            end
            REG_RD_DATA: begin
                w_rd_capture = 1'b1;
                w_next       = REG_RD_WAIT;
            end
            REG_RD_WAIT: begin
                if (!ulpi_dir_i) w_next = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            // Treat the bus as PHY-owned until DIR is seen low once, so the
            // data output enable stays low through and right after reset.
            r_dir_q     <= 1'b1;
            r_cmd       <= 8'h00;
            r_to_cnt    <= 16'd0;
            r_reg_busy  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_error  <= 1'b0;
            r_linestate <= 2'b00;
        end else begin
            r_state    <= w_next;
            r_dir_q    <= ulpi_dir_i;
            r_rx_valid <= 1'b0;

            if (w_start_tx)  r_cmd <= {4'h4, tx_data[3:0]};
            if (w_start_reg) r_cmd <= {2'b10, reg_addr};
            if (w_start_rd)  r_cmd <= {2'b11, reg_addr};

            if (w_start_reg || w_start_rd) r_reg_busy <= 1'b1;
            else if (reg_done)             r_reg_busy <= 1'b0;

            if (w_is_cmd && !ulpi_nxt_i) r_to_cnt <= r_to_cnt + 16'd1;
            else                         r_to_cnt <= 16'd0;

            if (ulpi_dir_i && r_dir_q) begin
                // Register-read data shares the bus with RX CMDs; keep it out.
                if (!w_rd_capture) begin
                    if (ulpi_nxt_i) begin
                        r_rx_data  <= ulpi_data_i;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_linestate <= ulpi_data_i[1:0];
                        case (ulpi_data_i[5:4])
                            2'b01: r_rx_active <= 1'b1;
                            2'b11: begin
                                r_rx_active <= 1'b1;
                                r_rx_error  <= 1'b1;
                            end
                            2'b00: begin
                                r_rx_active <= 1'b0;
                                r_rx_error  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (ulpi_dir_i && !r_dir_q) begin
                if (ulpi_nxt_i) r_rx_active <= 1'b1;
            end else if (!ulpi_dir_i && r_dir_q) begin
                r_rx_active <= 1'b0;
                r_rx_error  <= 1'b0;
            end
        end
    end

`ifdef ULPI_REG_READ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_reg_rd     <= 1'b0;
            r_reg_rdata  <= 8'h00;
            r_reg_rvalid <= 1'b0;
        end else begin
            r_reg_rvalid <= w_rd_capture;
            if (w_rd_capture) r_reg_rdata <= ulpi_data_i;
            if (w_start_reg)     r_reg_rd <= 1'b0;
            else if (w_start_rd) r_reg_rd <= 1'b1;
        end
    end
    assign reg_rdata  = r_reg_rdata;
    assign reg_rvalid = r_reg_rvalid;
    assign reg_done   = w_reg_done | r_reg_rvalid;
`else
    assign reg_done   = w_reg_done;
`endif

    assign ulpi_data_o  = w_data_o;
    assign ulpi_data_oe = w_bus_free;
    assign ulpi_stp_o   = w_stp;
    assign tx_ready     = w_tx_ready;
    assign tx_abort     = w_tx_abort;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_active    = r_rx_active;
    assign rx_error     = r_rx_error;
    assign linestate    = r_linestate;
    assign reg_busy     = r_reg_busy;

endmodule
`default_nettype wire
